// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths.
// SETUP is only meaningful to the master; the completer goes IDLE -> ACCESS.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETUP  = SETUP,
    ST_ACCESS = ACCESS
  } apb_state_e;

  // Wait counter is 4 bits wide; anything above 15 saturates.
  function automatic logic [3:0] wait_load(input int unsigned cycles);
    return (cycles > 15) ? 4'd15 : 4'(cycles);
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between one master and one completer (one psel line).
interface apb_slave_regfile_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register array: async clear, one synchronous write port,
// one combinational read port.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int DATA_W = APB_DATA_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: latches the setup phase, inserts WAIT_CYCLES wait states,
// then reads or writes the internal register file; out-of-range -> pslverr.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic                clk,
  input logic                rst,
  apb_slave_regfile_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  apb_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pready;
  logic              err;
  logic              we;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  // psel & penable while IDLE is a protocol violation and is simply ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr;
          wr_d    = bus.pwrite;
          wdata_d = bus.pwdata;
          cnt_d   = WAIT_LOAD;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
        end else if (bus.penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pready = (state_q == ST_ACCESS) & bus.psel & bus.penable & (cnt_q == 4'd0);
  assign err    = ({1'b0, addr_q} >= DEPTH_EXT);
  assign we     = pready & wr_q & ~err;

  apb_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (addr_q[IDX_W-1:0]),
    .wdata  (wdata_q),
    .raddr  (addr_q[IDX_W-1:0]),
    .rdata  (rdata)
  );

  assign bus.pready  = pready;
  assign bus.pslverr = pready & err;
  assign bus.prdata  = (pready & ~wr_q & ~err) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a 2-wait-state and a zero-wait instance
// share one driver; expected responses go through a scoreboard queue.
module tb_apb_slave_regfile;
  import apb_pkg::*;

  typedef struct {
    string      tag;
    logic [7:0] rdata;
    logic       slverr;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_zw = 1'b0;
  logic       psel_drv = 1'b0;
  logic       penable_drv = 1'b0;
  logic       pwrite_drv = 1'b0;
  logic [7:0] paddr_drv = 8'h00;
  logic [7:0] pwdata_drv = 8'h00;

  logic       mon_pready;
  logic [7:0] mon_prdata;
  logic       mon_pslverr;

  logic [7:0] model_w2 [16];
  logic [7:0] model_w0 [16];
  exp_t       sb_q [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) bus_w2 ();
  apb_slave_regfile_if #(.ADDR_W(8), .DATA_W(8)) bus_w0 ();

  assign bus_w2.psel    = psel_drv & ~sel_zw;
  assign bus_w2.penable = penable_drv;
  assign bus_w2.pwrite  = pwrite_drv;
  assign bus_w2.paddr   = paddr_drv;
  assign bus_w2.pwdata  = pwdata_drv;
  assign bus_w0.psel    = psel_drv & sel_zw;
  assign bus_w0.penable = penable_drv;
  assign bus_w0.pwrite  = pwrite_drv;
  assign bus_w0.paddr   = paddr_drv;
  assign bus_w0.pwdata  = pwdata_drv;

  assign mon_pready  = sel_zw ? bus_w0.pready  : bus_w2.pready;
  assign mon_prdata  = sel_zw ? bus_w0.prdata  : bus_w2.prdata;
  assign mon_pslverr = sel_zw ? bus_w0.pslverr : bus_w2.pslverr;

  apb_slave_regfile #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)
  ) dut_w2 (
    .clk (clk),
    .rst (rst),
    .bus (bus_w2)
  );

  apb_slave_regfile #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)
  ) dut_w0 (
    .clk (clk),
    .rst (rst),
    .bus (bus_w0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModels();
    for (int i = 0; i < 16; i++) begin
      model_w2[i] = 8'h00;
      model_w0[i] = 8'h00;
    end
  endtask

  // Entered and left at posedge+1; one full APB transfer on the selected DUT.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] data, input string tag);
    exp_t e;
    exp_t got;
    int   cyc;
    bit   done;
    e.tag    = tag;
    e.lat    = sel_zw ? 1 : 3;
    e.slverr = (addr >= 8'd16);
    if (!wr && addr < 8'd16) e.rdata = sel_zw ? model_w0[addr[3:0]] : model_w2[addr[3:0]];
    else                     e.rdata = 8'h00;
    sb_q.push_back(e);

    psel_drv = 1'b1; penable_drv = 1'b0;
    pwrite_drv = wr; paddr_drv = addr; pwdata_drv = data;
    @(posedge clk); #1;
    penable_drv = 1'b1;
    pwrite_drv = ~wr; paddr_drv = ~addr; pwdata_drv = ~data;

    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mon_pready === 1'b1) begin
        got = sb_q.pop_front();
        checkOutput({got.tag, " latency"}, 32'(cyc), 32'(got.lat));
        checkOutput({got.tag, " prdata"}, {24'h0, mon_prdata}, {24'h0, got.rdata});
        checkOutput({got.tag, " pslverr"}, {31'h0, mon_pslverr}, {31'h0, got.slverr});
        if (wr && addr < 8'd16) begin
          if (sel_zw) model_w0[addr[3:0]] = data;
          else        model_w2[addr[3:0]] = data;
        end
        done = 1'b1;
      end else begin
        checkOutput({tag, " wait prdata"}, {24'h0, mon_prdata}, 32'h0);
        checkOutput({tag, " wait pslverr"}, {31'h0, mon_pslverr}, 32'h0);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checkOutput({tag, " timeout"}, 32'h1, 32'h0);
      void'(sb_q.pop_front());
    end
    psel_drv = 1'b0;
    penable_drv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearModels();

    // Reset held for three cycles with psel toggling.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      psel_drv = ~psel_drv;
      penable_drv = (i == 1);
      @(negedge clk);
      checkOutput("reset pready", {31'h0, mon_pready}, 32'h0);
      checkOutput("reset prdata", {24'h0, mon_prdata}, 32'h0);
      checkOutput("reset pslverr", {31'h0, mon_pslverr}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; psel_drv = 1'b0; penable_drv = 1'b0;
    @(negedge clk);
    checkOutput("post-reset pready", {31'h0, mon_pready}, 32'h0);
    checkOutput("post-reset prdata", {24'h0, mon_prdata}, 32'h0);
    @(posedge clk); #1;

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 8'(a), 8'h00, "reset read");
    end

    applyStimulus(1'b1, 8'h03, 8'hA5, "write 03");
    applyStimulus(1'b0, 8'h03, 8'h00, "read 03");
    applyStimulus(1'b1, 8'h20, 8'h5A, "oor write");
    applyStimulus(1'b0, 8'h20, 8'h00, "oor read");
    applyStimulus(1'b0, 8'h00, 8'h00, "read 00 after oor");
    applyStimulus(1'b0, 8'h03, 8'h00, "read 03 after oor");

    // psel with penable while idle must be ignored.
    psel_drv = 1'b1; penable_drv = 1'b1; pwrite_drv = 1'b1;
    paddr_drv = 8'h05; pwdata_drv = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("violation pready", {31'h0, mon_pready}, 32'h0);
      @(posedge clk); #1;
    end
    psel_drv = 1'b0; penable_drv = 1'b0;
    applyStimulus(1'b0, 8'h05, 8'h00, "read 05 after violation");
    applyStimulus(1'b0, 8'h03, 8'h00, "read 03 after violation");

    // Abort: psel drops during the wait states of a write to 7.
    psel_drv = 1'b1; penable_drv = 1'b0; pwrite_drv = 1'b1;
    paddr_drv = 8'h07; pwdata_drv = 8'h3C;
    @(posedge clk); #1;
    penable_drv = 1'b1;
    @(negedge clk);
    checkOutput("abort wait pready", {31'h0, mon_pready}, 32'h0);
    @(posedge clk); #1;
    psel_drv = 1'b0; penable_drv = 1'b0;
    @(negedge clk);
    checkOutput("abort idle pready", {31'h0, mon_pready}, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h07, 8'h00, "read 07 after abort");

    // Reset asserted asynchronously during the completion cycle of a write.
    psel_drv = 1'b1; penable_drv = 1'b0; pwrite_drv = 1'b1;
    paddr_drv = 8'h07; pwdata_drv = 8'h77;
    @(posedge clk); #1;
    penable_drv = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    checkOutput("pre-reset pready", {31'h0, mon_pready}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("async reset pready", {31'h0, mon_pready}, 32'h0);
    checkOutput("async reset pslverr", {31'h0, mon_pslverr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; psel_drv = 1'b0; penable_drv = 1'b0;
    clearModels();
    @(posedge clk); #1;
    applyStimulus(1'b0, 8'h07, 8'h00, "read 07 after reset");
    applyStimulus(1'b0, 8'h03, 8'h00, "read 03 after reset");

    // Zero-wait instance, back-to-back write then read.
    sel_zw = 1'b1;
    applyStimulus(1'b1, 8'h00, 8'h11, "zw write 00");
    applyStimulus(1'b0, 8'h00, 8'h00, "zw read 00");
    applyStimulus(1'b1, 8'h0F, 8'hC3, "zw write 0f");
    applyStimulus(1'b0, 8'h0F, 8'h00, "zw read 0f");
    applyStimulus(1'b0, 8'h10, 8'h00, "zw oor read");

    checkOutput("scoreboard empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
